// File: rtl/majority_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : majority_seq_ctrl_if
// Description : Input word and output result valid/ready bundle for the
//               multi-cycle majority voter.
// Revision    : 1.0 - initial release
// ============================================================================
interface majority_seq_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH + 1)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_maj;
    logic [CW-1:0]    out_ones;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_maj, out_ones
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_maj, out_ones
    );
endinterface
`default_nettype wire

// File: rtl/majority_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : majority_seq_ctrl
// Description : Multi-cycle 32-bit majority voter; popcounts one CHUNK-bit
//               slice per cycle and reports ones count and majority bit.
// Revision    : 1.0 - initial release
// ============================================================================
module majority_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          clear,
    majority_seq_ctrl_if.slave bus,
    output logic               busy
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    // 2*ones >= WIDTH rewritten as ones >= ceil(WIDTH/2); ties vote 1.
    localparam logic [CW-1:0] MAJ_THRESH = CW'((WIDTH + 1) / 2);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [CW-1:0]    ones_q, ones_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             maj_q, maj_d;
    logic [CW-1:0]    res_ones_q, res_ones_d;

    logic [CHUNK-1:0] slice;
    logic [CW-1:0]    slice_cnt;
    logic [CW-1:0]    ones_sum;

    always_comb begin
        slice     = word_q[idx_q*CHUNK +: CHUNK];
        slice_cnt = '0;
        for (int i = 0; i < CHUNK; i++) begin
            slice_cnt = slice_cnt + CW'(slice[i]);
        end
        ones_sum  = ones_q + slice_cnt;
    end

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        ones_d     = ones_q;
        idx_d      = idx_q;
        maj_d      = maj_q;
        res_ones_d = res_ones_q;

        if (clear) begin
            // Abort keeps the last published result but drops any in-flight word.
            state_d = ST_IDLE;
            ones_d  = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        word_d  = bus.in_data;
                        ones_d  = '0;
                        idx_d   = '0;
                        state_d = ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    ones_d = ones_sum;
                    if (idx_q == IDX_LAST) begin
                        res_ones_d = ones_sum;
                        maj_d      = (ones_sum >= MAJ_THRESH);
                        state_d    = ST_DONE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            word_q     <= '0;
            ones_q     <= '0;
            idx_q      <= '0;
            maj_q      <= 1'b0;
            res_ones_q <= '0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            ones_q     <= ones_d;
            idx_q      <= idx_d;
            maj_q      <= maj_d;
            res_ones_q <= res_ones_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.out_maj   = maj_q;
    assign bus.out_ones  = res_ones_q;
    assign busy          = (state_q != ST_IDLE);

endmodule
`default_nettype wire
